// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request and response channels,
// a fixed wait-state count, byte/half/word lane access with sign or zero extension.
module dmem_responder #(
  parameter logic [31:0] BASE    = 32'h10010000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_w,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_uns,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         NO_WAIT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;

  logic        w_q;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic        a_w;
  logic [31:0] a_addr;
  logic [1:0]  a_width;
  logic        a_uns;
  logic [31:0] a_wdata;
  logic [31:0] idx_full;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        err;
  logic [31:0] rword;

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] ln,
                                               input logic [1:0] wd, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh  = word >> {ln, 3'b000};
    b   = sh[7:0];
    h   = sh[15:0];
    ext = sh;
    if (wd == 2'b00) begin
      if (uns) ext = $signed({24'h0, sh[7:0]});
      else     ext = 32'(b);
    end else if (wd == 2'b01) begin
      if (uns) ext = $signed({16'h0, sh[15:0]});
      else     ext = 32'(h);
    end
    return ext;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] ln, input logic [1:0] wd);
    logic [3:0]  be;
    logic [31:0] sh;
    logic [31:0] res;
    case (wd)
      2'b00:   be = 4'b0001 << ln;
      2'b01:   be = 4'b0011 << ln;
      default: be = 4'b1111;
    endcase
    sh  = wdata << {ln, 3'b000};
    res = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = sh[i*8 +: 8];
    end
    return res;
  endfunction

  // With zero wait states the access completes on the acceptance edge itself,
  // so the live request must be used instead of the (not yet loaded) latches.
  always_comb begin
    if (state == IDLE) begin
      a_w = req_w; a_addr = req_addr; a_width = req_width; a_uns = req_uns; a_wdata = req_wdata;
    end else begin
      a_w = w_q; a_addr = addr_q; a_width = width_q; a_uns = uns_q; a_wdata = wdata_q;
    end
  end

  assign idx_full = (a_addr - BASE) >> 2;
  assign idx      = idx_full[AW-1:0];
  assign lane     = a_addr[1:0];
  assign err      = (a_width == 2'b11)
                 || (a_width == 2'b01 && lane[0])
                 || (a_width == 2'b10 && lane != 2'b00)
                 || (a_addr < BASE)
                 || (idx_full >= 32'(DEPTH));
  assign rword    = mem[idx];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (NO_WAIT) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || a_w) ? 32'h0 : load_extract(rword, lane, a_width, a_uns);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      w_q     <= req_w;
      addr_q  <= req_addr;
      width_q <= req_width;
      uns_q   <= req_uns;
      wdata_q <= req_wdata;
    end
  end

  // Memory is deliberately outside the reset domain; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && a_w && !err) begin
      mem[idx] <= store_merge(rword, a_wdata, lane, a_width);
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE, default 32'h10010000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, extra wait cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port req_w  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_width  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_uns  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port resp_valid  output  1  response present.
REQ-014 SHALL have port resp_ready  input  1  response consumed when high with resp_valid.
REQ-015 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-016 SHALL have port resp_err  output  1  access faulted.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, one outstanding transaction.
REQ-018 SHALL drive req_ready high only in IDLE; SHALL latch all req_* on the acceptance edge.
REQ-019 SHALL, on acceptance with LATENCY=0, go directly to RESP; otherwise to WAIT, loading a counter with LATENCY-1.
REQ-020 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where it is 0; resp_valid first high exactly LATENCY+1 cycles after the acceptance edge.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready; SHALL return to IDLE on that edge.
REQ-022 SHALL not accept a new request in the same cycle the response is consumed (req_ready low in RESP).
REQ-023 SHALL compute word index = (addr - BASE) >> 2, lane = addr[1:0], little-endian lanes.
REQ-024 SHALL flag error when req_width = 11, half access with lane[0]=1, word access with lane != 0, addr < BASE, or index >= DEPTH.
REQ-025 SHALL, on error, perform no memory write and return resp_err=1, resp_rdata=0.
REQ-026 SHALL perform stores on the edge entering RESP, writing only the addressed lanes (1, 2 or 4 bytes) from low bytes of req_wdata.
REQ-027 SHALL, for loads, read the word on the edge entering RESP, extract the addressed byte/half/word, and extend per req_uns.
REQ-028 SHALL keep the memory array zero-initialised at time zero; a load after a store to the same address SHALL return the stored value.
REQ-029 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-030 SHALL, when rst high at a clock edge, enter IDLE, clear counter, drive resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 the following cycle.
REQ-031 SHALL discard any in-flight transaction on reset; a store still in WAIT SHALL not be written.
REQ-032 SHALL not clear memory contents on reset.
REQ-033 SHALL give rst priority over every other event in the same cycle.

Verification
REQ-034 SHALL verify: store word 0xDEADBEEF at 0x10010004, then load word same address, LATENCY=2 -> resp_valid 3 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL verify: after REQ-034, load byte 0x10010007 uns=0 -> 0xFFFFFFDE; uns=1 -> 0x000000DE; load half 0x10010004 uns=0 -> 0xFFFFBEEF.
REQ-036 SHALL verify: store byte 0x55 at 0x10010005 then load word 0x10010004 -> 0xDEAD55EF (other lanes untouched).
REQ-037 SHALL verify: load half at 0x10010003, word at 0x10010002, width=11, and address 0x10011000 (DEPTH=1024) -> err=1, rdata=0, memory unchanged.
REQ-038 SHALL verify: resp_ready held low 5 cycles -> resp_valid and data stable, req_ready low throughout; release -> IDLE next cycle.
REQ-039 SHALL verify: rst asserted during WAIT of a store 0x12345678 to 0x10010008 -> next cycle resp_valid=0, req_ready=1; subsequent load returns 0.
